// File: rtl/fetch_seq_pkg.sv
// fetch_seq_pkg
// Shared definitions for the fetch-unit load sequencer: FSM state encoding,
// bram_sel codes, load-mask bit positions and small decode helpers.
package fetch_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PREP   = 3'd1,
        ST_LOAD_A = 3'd2,
        ST_LOAD_B = 3'd3,
        ST_LOAD_I = 3'd4,
        ST_GAP    = 3'd5,
        ST_RUN    = 3'd6
    } state_t;

    localparam logic [1:0] SEL_A    = 2'b00;
    localparam logic [1:0] SEL_B    = 2'b01;
    localparam logic [1:0] SEL_I    = 2'b10;
    localparam logic [1:0] SEL_NONE = 2'b11;

    localparam int unsigned MASK_A = 0;
    localparam int unsigned MASK_B = 1;
    localparam int unsigned MASK_I = 2;

    // First still-pending phase in A, B, I order; RUN once none remain.
    function automatic state_t next_phase(input logic [2:0] pending);
        state_t s;
        if (pending[MASK_A])      s = ST_LOAD_A;
        else if (pending[MASK_B]) s = ST_LOAD_B;
        else if (pending[MASK_I]) s = ST_LOAD_I;
        else                      s = ST_RUN;
        return s;
    endfunction

    function automatic logic [1:0] phase_sel(input state_t s);
        logic [1:0] sel;
        case (s)
            ST_LOAD_A: sel = SEL_A;
            ST_LOAD_B: sel = SEL_B;
            ST_LOAD_I: sel = SEL_I;
            default:   sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/fetch_load_sequencer_beat_counter.sv
// beat_counter
// Saturating beat counter with an expected-length compare.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   clear       - zero the count (wins over inc)
//   inc         - count one accepted beat
//   expected    - expected beat number of the final beat
//   count       - beats counted so far
//   match       - the beat being accepted now is beat number `expected`
module beat_counter #(
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    input  logic [WIDTH-1:0] expected,
    output logic [WIDTH-1:0] count,
    output logic             match
);

    logic             sat;
    logic [WIDTH-1:0] beat_num;

    always_comb begin
        sat      = (count == '1);
        beat_num = sat ? count : count + WIDTH'(1);
        match    = (beat_num == expected);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && !sat) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/fetch_load_sequencer.sv
// fetch_load_sequencer
// Sequences the A / B / instruction load phases of the fetch unit, gates the
// DMA stream so beats pass only while a phase is open, checks phase lengths
// and starts the PE array once loading completes.
// Ports:
//   S_AXIS_ACLK, S_AXIS_ARESETN   - clock, synchronous active-low reset
//   cfg_start/row_width/load_mask - start pulse and configuration
//   S_AXIS_TVALID/TLAST/TREADY    - DMA stream handshake (TDATA bypasses)
//   FU_TVALID/FU_TLAST            - gated stream to the fetch unit
//   bram_sel, row_width           - target BRAM and latched row width
//   pe_start, pe_done             - PE array start pulse / completion
//   busy, done, err_cfg, err_len  - status
module fetch_load_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int unsigned BRAM_DEPTH       = 10,
    parameter int unsigned INSTR_BRAM_DEPTH = 11
) (
    input  logic        S_AXIS_ACLK,
    input  logic        S_AXIS_ARESETN,
    input  logic        cfg_start,
    input  logic [31:0] cfg_row_width,
    input  logic [2:0]  cfg_load_mask,
    input  logic        S_AXIS_TVALID,
    input  logic        S_AXIS_TLAST,
    output logic        S_AXIS_TREADY,
    output logic        FU_TVALID,
    output logic        FU_TLAST,
    output logic [1:0]  bram_sel,
    output logic [31:0] row_width,
    output logic        pe_start,
    input  logic        pe_done,
    output logic        busy,
    output logic        done,
    output logic        err_cfg,
    output logic        err_len
);

    localparam int unsigned LEN_W = BRAM_DEPTH + 1;
    localparam int unsigned CNT_W = INSTR_BRAM_DEPTH + 1;
    localparam logic [63:0] MATRIX_CAP = 64'd1 << BRAM_DEPTH;
    localparam logic [CNT_W-1:0] INSTR_CAP = CNT_W'(64'd1 << INSTR_BRAM_DEPTH);

    state_t             state;
    state_t             state_next;
    logic               prep_cnt;
    logic [2:0]         pending;
    logic [LEN_W-1:0]   sq_len;
    logic [63:0]        sq64;
    logic               cfg_valid;
    logic               start_ok;
    logic               in_load;
    logic               beat;
    logic               last_beat;
    logic               cnt_clear;
    logic [CNT_W-1:0]   expected_len;
    logic [CNT_W-1:0]   beat_count;
    logic               len_match;

    always_comb begin
        state_next    = state;
        sq64          = 64'(cfg_row_width) * 64'(cfg_row_width);
        cfg_valid     = (cfg_row_width != '0) && (sq64 <= MATRIX_CAP);
        start_ok      = (state == ST_IDLE) && cfg_start && cfg_valid;
        in_load       = (state == ST_LOAD_A) || (state == ST_LOAD_B) ||
                        (state == ST_LOAD_I);
        S_AXIS_TREADY = in_load;
        FU_TVALID     = in_load && S_AXIS_TVALID;
        FU_TLAST      = in_load && S_AXIS_TVALID && S_AXIS_TLAST;
        beat          = in_load && S_AXIS_TVALID;
        last_beat     = beat && S_AXIS_TLAST;
        cnt_clear     = start_ok || last_beat;
        expected_len  = CNT_W'(sq_len);

        case (state)
            ST_IDLE:   if (start_ok) state_next = ST_PREP;
            ST_PREP:   if (prep_cnt) state_next = next_phase(pending);
            ST_LOAD_A,
            ST_LOAD_B,
            ST_LOAD_I: if (last_beat) state_next = ST_GAP;
            ST_GAP:    state_next = next_phase(pending);
            ST_RUN:    if (pe_done) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge S_AXIS_ACLK) begin
        if (!S_AXIS_ARESETN) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    beat_counter #(
        .WIDTH(CNT_W)
    ) u_beat_counter (
        .clk      (S_AXIS_ACLK),
        .rst_n    (S_AXIS_ARESETN),
        .clear    (cnt_clear),
        .inc      (beat),
        .expected (expected_len),
        .count    (beat_count),
        .match    (len_match)
    );

    always_ff @(posedge S_AXIS_ACLK) begin
        if (!S_AXIS_ARESETN) begin
            prep_cnt  <= 1'b0;
            pending   <= '0;
            sq_len    <= '0;
            row_width <= '0;
            bram_sel  <= SEL_NONE;
            pe_start  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_cfg   <= 1'b0;
            err_len   <= 1'b0;
        end else begin
            // Two PREP cycles: prep_cnt is 0 on the first, 1 on the second.
            prep_cnt <= (state == ST_PREP) ? ~prep_cnt : 1'b0;

            // Registered outputs are decoded from state_next so they are
            // aligned with the state register rather than a cycle behind.
            bram_sel <= phase_sel(state_next);
            busy     <= (state_next != ST_IDLE);
            pe_start <= (state_next == ST_RUN) && (state != ST_RUN);

            if ((state == ST_IDLE) && cfg_start) begin
                if (cfg_valid) begin
                    row_width <= cfg_row_width;
                    sq_len    <= sq64[LEN_W-1:0];
                    pending   <= cfg_load_mask;
                    done      <= 1'b0;
                    err_cfg   <= 1'b0;
                    err_len   <= 1'b0;
                end else begin
                    err_cfg <= 1'b1;
                end
            end

            // Retire a phase as soon as it is open so GAP picks the next one.
            case (state)
                ST_LOAD_A: pending[MASK_A] <= 1'b0;
                ST_LOAD_B: pending[MASK_B] <= 1'b0;
                ST_LOAD_I: pending[MASK_I] <= 1'b0;
                default:   ;
            endcase

            if (last_beat && ((state == ST_LOAD_A) || (state == ST_LOAD_B)) &&
                !len_match) begin
                err_len <= 1'b1;
            end
            // beat_count holds the beats before this one, so count >= cap
            // means this beat's number exceeds the instruction capacity.
            if (beat && (state == ST_LOAD_I) && (beat_count >= INSTR_CAP)) begin
                err_len <= 1'b1;
            end

            if ((state == ST_RUN) && pe_done) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_load_sequencer.sv
`timescale 1ns/1ps
module tb_fetch_load_sequencer;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        cfg_start = 1'b0;
    logic [31:0] cfg_row_width = '0;
    logic [2:0]  cfg_load_mask = '0;
    logic        tvalid = 1'b0;
    logic        tlast = 1'b0;
    logic        tready;
    logic        fu_tvalid;
    logic        fu_tlast;
    logic [1:0]  bram_sel;
    logic [31:0] row_width;
    logic        pe_start;
    logic        pe_done = 1'b0;
    logic        busy;
    logic        done;
    logic        err_cfg;
    logic        err_len;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_load_sequencer #(
        .BRAM_DEPTH(10),
        .INSTR_BRAM_DEPTH(11)
    ) dut (
        .S_AXIS_ACLK    (clk),
        .S_AXIS_ARESETN (aresetn),
        .cfg_start      (cfg_start),
        .cfg_row_width  (cfg_row_width),
        .cfg_load_mask  (cfg_load_mask),
        .S_AXIS_TVALID  (tvalid),
        .S_AXIS_TLAST   (tlast),
        .S_AXIS_TREADY  (tready),
        .FU_TVALID      (fu_tvalid),
        .FU_TLAST       (fu_tlast),
        .bram_sel       (bram_sel),
        .row_width      (row_width),
        .pe_start       (pe_start),
        .pe_done        (pe_done),
        .busy           (busy),
        .done           (done),
        .err_cfg        (err_cfg),
        .err_len        (err_len)
    );

    // Inputs change 1 ns after the rising edge; outputs are read on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives cfg_start during the current cycle (cycle 0); returns in cycle 1.
    task automatic do_start(input logic [31:0] rw, input logic [2:0] mask);
        cfg_start     = 1'b1;
        cfg_row_width = rw;
        cfg_load_mask = mask;
        tick();
        cfg_start = 1'b0;
    endtask

    // Sends n beats starting in the current cycle, TLAST on the last one.
    // With toggle, an idle cycle (TVALID=0, TLAST=1) sits between beats.
    // Returns in the cycle after the TLAST beat.
    task automatic send_beats(input int n, input bit toggle, output logic [1:0] sel_first,
                              output int lo_cnt, output int fv_cnt, output int fl_cnt);
        lo_cnt = 0; fv_cnt = 0; fl_cnt = 0; sel_first = 2'bxx;
        for (int i = 1; i <= n; i++) begin
            tvalid = 1'b1;
            tlast  = (i == n);
            @(negedge clk);
            if (i == 1) sel_first = bram_sel;
            if (tready !== 1'b1) lo_cnt++;
            if (fu_tvalid === 1'b1) fv_cnt++;
            if (fu_tlast === 1'b1) fl_cnt++;
            tick();
            if (toggle && i != n) begin
                tvalid = 1'b0;
                tlast  = 1'b1;
                @(negedge clk);
                if (tready !== 1'b1) lo_cnt++;
                if (fu_tvalid === 1'b1) fv_cnt++;
                if (fu_tlast === 1'b1) fl_cnt++;
                tick();
            end
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        tvalid  = 1'b1;
        tick();
        tick();
        @(negedge clk);
        n_checks++;
        if ({tready, fu_tvalid, fu_tlast, bram_sel, pe_start, busy, done, err_cfg, err_len} !== 10'b000_11_00000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected %b",
                     {tready, fu_tvalid, fu_tlast, bram_sel, pe_start, busy, done, err_cfg, err_len}, 10'b000_11_00000);
        end
        n_checks++;
        if (row_width !== 32'd0) begin
            n_fail++; $display("FAIL reset_row_width: got %0d expected 0", row_width);
        end
        tick();
        aresetn = 1'b1;
        tvalid  = 1'b0;
        tick();
    endtask

    task automatic test_full_load();
        logic [1:0] sel;
        int lo, fv, fl;
        do_start(32'd4, 3'b111);
        @(negedge clk);
        n_checks++;
        if ({busy, tready} !== 2'b10) begin
            n_fail++; $display("FAIL full_prep1: busy,tready got %b expected 10", {busy, tready});
        end
        n_checks++;
        if (row_width !== 32'd4) begin
            n_fail++; $display("FAIL full_row_width: got %0d expected 4", row_width);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if ({tready, bram_sel} !== 3'b011) begin
            n_fail++; $display("FAIL full_prep2: tready,bram_sel got %b expected 011", {tready, bram_sel});
        end
        tick();
        send_beats(16, 1'b0, sel, lo, fv, fl);
        n_checks++;
        if ({sel, 8'(lo), 8'(fv), 8'(fl)} !== {2'b00, 8'd0, 8'd16, 8'd1}) begin
            n_fail++; $display("FAIL full_phase_a: sel=%b lo=%0d fv=%0d fl=%0d expected sel=00 lo=0 fv=16 fl=1", sel, lo, fv, fl);
        end
        tvalid = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({tready, fu_tvalid, bram_sel} !== 4'b0011) begin
            n_fail++; $display("FAIL full_gap_ab: tready,fu_tvalid,bram_sel got %b expected 0011", {tready, fu_tvalid, bram_sel});
        end
        tick();
        send_beats(16, 1'b0, sel, lo, fv, fl);
        n_checks++;
        if ({sel, 8'(lo), 8'(fv), 8'(fl)} !== {2'b01, 8'd0, 8'd16, 8'd1}) begin
            n_fail++; $display("FAIL full_phase_b: sel=%b lo=%0d fv=%0d fl=%0d expected sel=01 lo=0 fv=16 fl=1", sel, lo, fv, fl);
        end
        tvalid = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({tready, fu_tvalid, bram_sel} !== 4'b0011) begin
            n_fail++; $display("FAIL full_gap_bi: tready,fu_tvalid,bram_sel got %b expected 0011", {tready, fu_tvalid, bram_sel});
        end
        tick();
        send_beats(5, 1'b0, sel, lo, fv, fl);
        n_checks++;
        if ({sel, 8'(lo), 8'(fv), 8'(fl)} !== {2'b10, 8'd0, 8'd5, 8'd1}) begin
            n_fail++; $display("FAIL full_phase_i: sel=%b lo=%0d fv=%0d fl=%0d expected sel=10 lo=0 fv=5 fl=1", sel, lo, fv, fl);
        end
        @(negedge clk);
        n_checks++;
        if ({pe_start, tready} !== 2'b00) begin
            n_fail++; $display("FAIL full_gap_run: pe_start,tready got %b expected 00", {pe_start, tready});
        end
        tick();
        @(negedge clk);
        n_checks++;
        if ({pe_start, busy, bram_sel} !== 4'b1111) begin
            n_fail++; $display("FAIL full_pe_start: pe_start,busy,bram_sel got %b expected 1111", {pe_start, busy, bram_sel});
        end
        tick();
        pe_done = 1'b1;
        @(negedge clk);
        n_checks++;
        if (pe_start !== 1'b0) begin
            n_fail++; $display("FAIL full_pe_start_single: got %b expected 0", pe_start);
        end
        tick();
        pe_done = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({done, busy, err_cfg, err_len} !== 4'b1000) begin
            n_fail++; $display("FAIL full_done: done,busy,err_cfg,err_len got %b expected 1000", {done, busy, err_cfg, err_len});
        end
        tick();
    endtask

    task automatic test_toggle_valid();
        logic [1:0] sel;
        int lo, fv, fl;
        do_start(32'd4, 3'b001);
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++; $display("FAIL toggle_done_cleared: got %b expected 0", done);
        end
        tick();
        tick();
        send_beats(16, 1'b1, sel, lo, fv, fl);
        n_checks++;
        if ({sel, 8'(lo), 8'(fv), 8'(fl)} !== {2'b00, 8'd0, 8'd16, 8'd1}) begin
            n_fail++; $display("FAIL toggle_phase_a: sel=%b lo=%0d fv=%0d fl=%0d expected sel=00 lo=0 fv=16 fl=1", sel, lo, fv, fl);
        end
        tick();
        pe_done = 1'b1;
        tick();
        pe_done = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({done, busy, err_len} !== 3'b100) begin
            n_fail++; $display("FAIL toggle_end: done,busy,err_len got %b expected 100", {done, busy, err_len});
        end
        tick();
    endtask

    task automatic test_short_a();
        logic [1:0] sel;
        int lo, fv, fl;
        do_start(32'd4, 3'b011);
        tick();
        tick();
        send_beats(15, 1'b0, sel, lo, fv, fl);
        @(negedge clk);
        n_checks++;
        if ({err_len, tready} !== 2'b10) begin
            n_fail++; $display("FAIL short_err_len: err_len,tready got %b expected 10", {err_len, tready});
        end
        tick();
        send_beats(16, 1'b0, sel, lo, fv, fl);
        n_checks++;
        if ({sel, 8'(lo)} !== {2'b01, 8'd0}) begin
            n_fail++; $display("FAIL short_phase_b: sel=%b lo=%0d expected sel=01 lo=0", sel, lo);
        end
        tick();
        pe_done = 1'b1;
        tick();
        pe_done = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({done, busy, err_len} !== 3'b101) begin
            n_fail++; $display("FAIL short_end: done,busy,err_len got %b expected 101", {done, busy, err_len});
        end
        tick();
    endtask

    task automatic test_bad_cfg();
        tvalid = 1'b1;
        do_start(32'd33, 3'b111);
        @(negedge clk);
        n_checks++;
        if ({err_cfg, busy, tready, done, err_len} !== 5'b10011) begin
            n_fail++; $display("FAIL badcfg_33: err_cfg,busy,tready,done,err_len got %b expected 10011", {err_cfg, busy, tready, done, err_len});
        end
        n_checks++;
        if (row_width !== 32'd4) begin
            n_fail++; $display("FAIL badcfg_row_width: got %0d expected 4", row_width);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if ({busy, tready, fu_tvalid, bram_sel} !== 5'b00011) begin
            n_fail++; $display("FAIL badcfg_idle: busy,tready,fu_tvalid,bram_sel got %b expected 00011", {busy, tready, fu_tvalid, bram_sel});
        end
        tvalid = 1'b0;
        tick();
    endtask

    task automatic test_mask_zero();
        int ready_hi = 0;
        tvalid = 1'b1;
        do_start(32'd32, 3'b000);
        pe_done = 1'b1;
        @(negedge clk);
        if (tready === 1'b1) ready_hi++;
        n_checks++;
        if ({err_cfg, err_len, done, busy} !== 4'b0001) begin
            n_fail++; $display("FAIL mask0_start: err_cfg,err_len,done,busy got %b expected 0001", {err_cfg, err_len, done, busy});
        end
        n_checks++;
        if (row_width !== 32'd32) begin
            n_fail++; $display("FAIL mask0_row_width: got %0d expected 32", row_width);
        end
        tick();
        pe_done = 1'b0;
        @(negedge clk);
        if (tready === 1'b1) ready_hi++;
        n_checks++;
        if (pe_start !== 1'b0) begin
            n_fail++; $display("FAIL mask0_cycle2: pe_start got %b expected 0", pe_start);
        end
        tick();
        @(negedge clk);
        if (tready === 1'b1) ready_hi++;
        n_checks++;
        if ({pe_start, done} !== 2'b10) begin
            n_fail++; $display("FAIL mask0_cycle3: pe_start,done got %b expected 10", {pe_start, done});
        end
        tick();
        pe_done = 1'b1;
        @(negedge clk);
        if (tready === 1'b1) ready_hi++;
        tick();
        pe_done = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({done, busy} !== 2'b10) begin
            n_fail++; $display("FAIL mask0_done: done,busy got %b expected 10", {done, busy});
        end
        n_checks++;
        if (ready_hi !== 0) begin
            n_fail++; $display("FAIL mask0_tready: high for %0d cycles expected 0", ready_hi);
        end
        tvalid = 1'b0;
        tick();
        do_start(32'd0, 3'b111);
        @(negedge clk);
        n_checks++;
        if ({err_cfg, busy} !== 2'b10) begin
            n_fail++; $display("FAIL badcfg_zero: err_cfg,busy got %b expected 10", {err_cfg, busy});
        end
        tick();
    endtask

    task automatic test_instr_bounds();
        logic [1:0] sel;
        int lo, fv, fl;
        do_start(32'd1, 3'b100);
        tick();
        tick();
        send_beats(2048, 1'b0, sel, lo, fv, fl);
        @(negedge clk);
        n_checks++;
        if ({sel, err_len, err_cfg} !== 4'b1000) begin
            n_fail++; $display("FAIL instr_2048: sel,err_len,err_cfg got %b expected 1000", {sel, err_len, err_cfg});
        end
        tick();
        pe_done = 1'b1;
        tick();
        pe_done = 1'b0;
        tick();
        do_start(32'd1, 3'b100);
        tick();
        tick();
        send_beats(2049, 1'b0, sel, lo, fv, fl);
        @(negedge clk);
        n_checks++;
        if ({err_len, 16'(fv)} !== {1'b1, 16'd2049}) begin
            n_fail++; $display("FAIL instr_2049: err_len=%b fv=%0d expected err_len=1 fv=2049", err_len, fv);
        end
        tick();
        pe_done = 1'b1;
        tick();
        pe_done = 1'b0;
        tick();
    endtask

    task automatic test_mid_reset();
        logic [1:0] sel;
        int lo, fv, fl;
        do_start(32'd2, 3'b011);
        tick();
        tick();
        send_beats(4, 1'b0, sel, lo, fv, fl);
        tick();
        tvalid = 1'b1;
        tlast  = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bram_sel, tready} !== 3'b011) begin
            n_fail++; $display("FAIL midrst_load_b: bram_sel,tready got %b expected 011", {bram_sel, tready});
        end
        tick();
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({tready, fu_tvalid, fu_tlast, bram_sel, pe_start, busy, done, err_cfg, err_len} !== 10'b000_11_00000) begin
            n_fail++;
            $display("FAIL midrst_outputs: got %b expected %b",
                     {tready, fu_tvalid, fu_tlast, bram_sel, pe_start, busy, done, err_cfg, err_len}, 10'b000_11_00000);
        end
        n_checks++;
        if (row_width !== 32'd0) begin
            n_fail++; $display("FAIL midrst_row_width: got %0d expected 0", row_width);
        end
        tvalid = 1'b0;
        tick();
        do_start(32'd1, 3'b100);
        tick();
        tick();
        send_beats(3, 1'b0, sel, lo, fv, fl);
        n_checks++;
        if ({sel, 8'(lo), 8'(fv)} !== {2'b10, 8'd0, 8'd3}) begin
            n_fail++; $display("FAIL midrst_restart: sel=%b lo=%0d fv=%0d expected sel=10 lo=0 fv=3", sel, lo, fv);
        end
        tick();
        pe_done = 1'b1;
        tick();
        pe_done = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({done, busy, err_len, err_cfg} !== 4'b1000) begin
            n_fail++; $display("FAIL midrst_end: done,busy,err_len,err_cfg got %b expected 1000", {done, busy, err_len, err_cfg});
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_toggle_valid();
        test_short_a();
        test_bad_cfg();
        test_mask_zero();
        test_instr_bounds();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
